// File: rtl/lighthouse_scan_scheduler.sv
// lighthouse_scan_scheduler
// Round-robin scheduler that time-shares one lighthouse measurement engine
// across up to NUM_SENSORS sensors and keeps a per-sensor result bank that
// the HPS reads over a never-stalling Avalon-MM slave.
// Optional build macro: SCAN_TIMEOUT_EN. When defined, ARM/BUSY are bounded
// by TIMEOUT_CYCLES, and a timed-out sensor stores 0xFFFFFFFF.
module lighthouse_scan_scheduler #(
    parameter int NUM_SENSORS    = 16,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4:0]             address,
    input  logic                   write,
    input  logic [31:0]            writedata,
    input  logic                   read,
    output logic [31:0]            readdata,
    output logic                   waitrequest,
    input  logic [NUM_SENSORS-1:0] sensor_signal_i,
    output logic                   meas_sensor,
    output logic                   meas_start,
    input  logic                   meas_ready,
    input  logic [31:0]            meas_duration
);
    localparam int SEL_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        START  = 3'd2,
        ARM    = 3'd3,
        BUSY   = 3'd4,
        STORE  = 3'd5
    } state_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic        wr;
        logic [31:0] data;
    } bus_req_t;

    bus_req_t                          req;
    state_t                            state, state_nxt;
    logic                              ctrl_en, ctrl_single;
    logic [NUM_SENSORS-1:0]            mask;
    logic [31:0]                       sweeps;
    logic [SEL_W-1:0]                  cur_sel;
    logic                              sweep_start;
    logic [SEL_W-1:0]                  low_idx, nxt_idx;
    logic                              nxt_found;
    logic                              sweep_done, end_single;
    logic                              wr_ctrl, wr_mask, wr_valid;
    logic                              to_tmo, tmo_expire, tmo_hit, tmo_flag;
    logic [31:0]                       store_dur;
    logic [NUM_SENSORS-1:0][31:0]      lane_result;
    logic [NUM_SENSORS-1:0]            lane_fresh;
    logic [31:0]                       status;
    logic                              unused_bus;

    assign req         = '{addr: address, wr: write, data: writedata};
    assign wr_ctrl     = req.wr && (req.addr == 5'd0);
    assign wr_mask     = req.wr && (req.addr == 5'd1);
    assign wr_valid    = req.wr && (req.addr == 5'd4);
    assign waitrequest = 1'b0;
    assign unused_bus  = ^{read, writedata};

    assign meas_sensor = sensor_signal_i[cur_sel];
    assign meas_start  = (state == START);

    // lowest enabled index overall and lowest enabled index above cur_sel
    always_comb begin
        low_idx   = '0;
        nxt_idx   = '0;
        nxt_found = 1'b0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = SEL_W'(i);
                if (i > int'(cur_sel)) begin
                    nxt_idx   = SEL_W'(i);
                    nxt_found = 1'b1;
                end
            end
        end
    end

    // a sweep ends when nothing enabled remains above the sensor just stored
    assign sweep_done = (state == STORE) && !nxt_found;
    assign end_single = sweep_done && ctrl_single;

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state logic; a timeout diverts ARM/BUSY straight to STORE
    always_comb begin
        state_nxt = state;
        to_tmo    = 1'b0;
        case (state)
            IDLE:   if (ctrl_en && (|mask)) state_nxt = SELECT;
            SELECT: state_nxt = (|mask) ? START : IDLE;
            START:  state_nxt = ARM;
            ARM: begin
                if (!meas_ready) state_nxt = BUSY;
                else if (tmo_expire) begin
                    state_nxt = STORE;
                    to_tmo    = 1'b1;
                end
            end
            BUSY: begin
                if (meas_ready) state_nxt = STORE;
                else if (tmo_expire) begin
                    state_nxt = STORE;
                    to_tmo    = 1'b1;
                end
            end
            STORE:  state_nxt = (!ctrl_en || end_single || !(|mask)) ? IDLE : SELECT;
            default: state_nxt = IDLE;
        endcase
    end

    // sensor pointer and sweep counter; a fresh sweep restarts at the lowest enabled sensor
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_sel     <= '0;
            sweep_start <= 1'b1;
            sweeps      <= '0;
        end else begin
            if (state == SELECT && (|mask)) begin
                cur_sel     <= (sweep_start || !nxt_found) ? low_idx : nxt_idx;
                sweep_start <= 1'b0;
            end
            if (sweep_done) begin
                sweeps      <= sweeps + 32'd1;
                sweep_start <= 1'b1;
            end
        end
    end

    // host-writable control; single-sweep completion overrides a same-cycle enable write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_en     <= 1'b0;
            ctrl_single <= 1'b0;
            mask        <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= req.data[0];
                ctrl_single <= req.data[1];
            end
            if (end_single) ctrl_en <= 1'b0;
            if (wr_mask)    mask <= req.data[NUM_SENSORS-1:0];
        end
    end

`ifdef SCAN_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    assign tmo_expire = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    // phase watchdog: reloads entering ARM and BUSY, flags sticky until cleared via CTRL b2
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt  <= '0;
            tmo_hit  <= 1'b0;
            tmo_flag <= 1'b0;
        end else begin
            if (state == START || (state == ARM && !meas_ready)) tmo_cnt <= '0;
            else if (state == ARM || state == BUSY)               tmo_cnt <= tmo_cnt + 32'd1;
            tmo_hit <= to_tmo;
            if (wr_ctrl && req.data[2])   tmo_flag <= 1'b0;
            if (state == STORE && tmo_hit) tmo_flag <= 1'b1;
        end
    end
`else
    localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
    logic unused_tmo;
    assign unused_tmo = to_tmo;
    assign tmo_expire = 1'b0;
    assign tmo_hit    = 1'b0;
    assign tmo_flag   = 1'b0;
`endif

    assign store_dur = tmo_hit ? 32'hFFFF_FFFF : meas_duration;

    // per-sensor result bank; a STORE set beats a same-cycle W1C clear
    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_lane
        logic lane_store, lane_clear;
        assign lane_store = (state == STORE) && (cur_sel == SEL_W'(g));
        assign lane_clear = wr_valid && req.data[g];

        // capture the duration and fresh bit for this sensor
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                lane_result[g] <= '0;
                lane_fresh[g]  <= 1'b0;
            end else begin
                if (lane_store)      lane_result[g] <= store_dur;
                if (lane_store)      lane_fresh[g]  <= 1'b1;
                else if (lane_clear) lane_fresh[g]  <= 1'b0;
            end
        end
    end

    assign status = {21'd0, state, cur_sel, 2'b00, tmo_flag, (state != IDLE)};

    // combinational read mux, decoded from address alone
    always_comb begin
        readdata = 32'hDEAD_BEEF;
        if (address[4]) begin
            if (int'(address[3:0]) < NUM_SENSORS) readdata = lane_result[address[3:0]];
        end else begin
            case (address)
                5'd0: readdata = {30'd0, ctrl_single, ctrl_en};
                5'd1: readdata = 32'(mask);
                5'd2: readdata = status;
                5'd3: readdata = sweeps;
                5'd4: readdata = 32'(lane_fresh);
                default: readdata = 32'hDEAD_BEEF;
            endcase
        end
    end
endmodule
